// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the byte sorter front end
//
// Purpose: byte and frame types used by the frame collector and the sorter.
// Ports: none (package).
package sort_pkg;

    localparam int BYTE_W    = 8;
    localparam int FRAME_LEN = 8;
    localparam int FRAME_W   = BYTE_W * FRAME_LEN;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef byte_t frame_t [FRAME_LEN];

    // Collector fill level: 0..7 partial, 8 = full frame parked behind the output.
    localparam logic [3:0] CNT_LAST = 4'd7;
    localparam logic [3:0] CNT_FULL = 4'd8;

endpackage

// File: rtl/frame_out_reg.sv
// rtl/frame_out_reg.sv - frame-wide output register with valid/ready hold
//
// Purpose: registers a complete frame and holds it until downstream takes it.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_load           capture i_frame and raise o_valid
//   i_ready          downstream consumes the held frame this cycle
//   i_frame          frame to capture, byte 0 in the low bits
//   o_valid          o_frame holds an unconsumed frame
//   o_frame          registered frame, only changes on a load
module frame_out_reg
    import sort_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_ready,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_valid,
    output logic [FRAME_W-1:0] o_frame
);

    logic               r_valid;
    logic [FRAME_W-1:0] r_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_frame <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_frame <= i_frame;
        end else if (i_ready) begin
            // Frame bytes are left in place after a handoff; only valid drops.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_frame = r_frame;

endmodule

// File: rtl/sort_frame_collector.sv
// rtl/sort_frame_collector.sv - gathers 8 streamed bytes into a parallel frame
//
// Purpose: deserialises a byte stream into 8-byte frames for the sorting network.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 discard partially collected (or parked) frame
//   in_valid/in_ready     input byte handshake, in_data is the byte
//   out_valid/out_ready   output frame handshake
//   frame_a..frame_h      frame bytes, frame_a received first
//   frame_count           completed handoffs, wraps at 16 bits
module sort_frame_collector
    import sort_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  frame_a,
    output logic [7:0]  frame_b,
    output logic [7:0]  frame_c,
    output logic [7:0]  frame_d,
    output logic [7:0]  frame_e,
    output logic [7:0]  frame_f,
    output logic [7:0]  frame_g,
    output logic [7:0]  frame_h,
    output logic [15:0] frame_count
);

    // r_slot[7] only fills when the 8th byte arrives while the output is busy.
    byte_t       r_slot [FRAME_LEN];
    logic [3:0]  r_cnt;
    logic [15:0] r_frame_count;

    logic               w_out_valid;
    logic [FRAME_W-1:0] w_frame_out;
    logic [FRAME_W-1:0] w_frame_in;
    logic               w_out_free;
    logic               w_accept;
    logic               w_load_direct;
    logic               w_load_held;
    logic               w_load;

    assign in_ready   = (r_cnt != CNT_FULL);
    assign w_out_free = !w_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready && !flush;

    // 8th byte goes straight to the output bank, bypassing r_slot[7].
    assign w_load_direct = w_accept && (r_cnt == CNT_LAST) && w_out_free;
    assign w_load_held   = !flush && (r_cnt == CNT_FULL) && w_out_free;
    assign w_load        = w_load_direct || w_load_held;

    always_comb begin
        w_frame_in = '0;
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            w_frame_in[i*BYTE_W +: BYTE_W] = r_slot[i];
        end
        w_frame_in[(FRAME_LEN-1)*BYTE_W +: BYTE_W] =
            w_load_direct ? in_data : r_slot[FRAME_LEN-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_slot[i] <= '0;
            end
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_slot[r_cnt[2:0]] <= in_data;
            r_cnt              <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (w_out_valid && out_ready) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    frame_out_reg u_frame_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_ready (out_ready),
        .i_frame (w_frame_in),
        .o_valid (w_out_valid),
        .o_frame (w_frame_out)
    );

    assign out_valid   = w_out_valid;
    assign frame_count = r_frame_count;
    assign frame_a     = w_frame_out[0*BYTE_W +: BYTE_W];
    assign frame_b     = w_frame_out[1*BYTE_W +: BYTE_W];
    assign frame_c     = w_frame_out[2*BYTE_W +: BYTE_W];
    assign frame_d     = w_frame_out[3*BYTE_W +: BYTE_W];
    assign frame_e     = w_frame_out[4*BYTE_W +: BYTE_W];
    assign frame_f     = w_frame_out[5*BYTE_W +: BYTE_W];
    assign frame_g     = w_frame_out[6*BYTE_W +: BYTE_W];
    assign frame_h     = w_frame_out[7*BYTE_W +: BYTE_W];

endmodule

// File: tb/tb_sort_frame_collector.sv
// tb/tb_sort_frame_collector.sv - self-checking bench for sort_frame_collector
module tb_sort_frame_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  fa, fb, fc, fd, fe, ff, fg, fh;
    logic [15:0] frame_count;
    logic [7:0]  fo [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_frame_collector dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_a     (fa),
        .frame_b     (fb),
        .frame_c     (fc),
        .frame_d     (fd),
        .frame_e     (fe),
        .frame_f     (ff),
        .frame_g     (fg),
        .frame_h     (fh),
        .frame_count (frame_count)
    );

    assign fo[0] = fa;
    assign fo[1] = fb;
    assign fo[2] = fc;
    assign fo[3] = fd;
    assign fo[4] = fe;
    assign fo[5] = ff;
    assign fo[6] = fg;
    assign fo[7] = fh;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the collector is a FIFO of up to 8 accepted bytes; a
    // full set of 8 moves to the output as soon as the output is free.
    logic [7:0]  m_pend [$];
    logic [7:0]  m_frame [8];
    logic        m_valid;
    logic [15:0] m_count;
    logic        m_started = 1'b0;
    logic        m_handoff;
    logic        m_free;

    always @(posedge clk) begin
        if (rst) begin
            m_pend.delete();
            m_valid   = 1'b0;
            m_count   = 16'd0;
            for (int i = 0; i < 8; i++) m_frame[i] = 8'h00;
            m_started = 1'b1;
        end else if (m_started) begin
            m_handoff = m_valid && out_ready;
            m_free    = !m_valid || out_ready;
            if (flush) m_pend.delete();
            else if (in_valid && m_pend.size() != 8) m_pend.push_back(in_data);
            if (!flush && m_pend.size() == 8 && m_free) begin
                for (int i = 0; i < 8; i++) m_frame[i] = m_pend[i];
                m_pend.delete();
                m_valid = 1'b1;
            end else if (m_handoff) begin
                m_valid = 1'b0;
            end
            if (m_handoff) m_count = m_count + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready", int'(in_ready), int'(m_pend.size() != 8));
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("frame_count", int'(frame_count), int'(m_count));
            for (int i = 0; i < 8; i++)
                chk($sformatf("frame[%0d]", i), int'(fo[i]), int'(m_frame[i]));
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic ordy,
                       input logic fl, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    int pulses;
    int last_pulse;
    int ready_lows;

    initial begin
        // Reset state
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_frame_count", int'(frame_count), 0);

        // Single frame 0x10..0x80
        for (int i = 0; i < 8; i++) cyc(1, 8'((i + 1) * 16), 1, 0, 0);
        chk("f1_out_valid", int'(out_valid), 1);
        chk("f1_frame_a", int'(fa), 'h10);
        chk("f1_frame_d", int'(fd), 'h40);
        chk("f1_frame_h", int'(fh), 'h80);
        cyc(0, 8'h00, 1, 0, 0);
        chk("f1_count", int'(frame_count), 1);
        chk("f1_valid_drop", int'(out_valid), 0);

        // Three back-to-back frames
        cyc(0, 8'h00, 0, 0, 1);
        pulses = 0; last_pulse = -1; ready_lows = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(1, 8'(i), 1, 0, 0);
            if (out_valid) begin pulses++; last_pulse = i; end
            if (!in_ready) ready_lows++;
        end
        chk("b2b_pulses", pulses, 3);
        chk("b2b_last_pulse", last_pulse, 23);
        chk("b2b_ready_lows", ready_lows, 0);
        chk("b2b_frame_a", int'(fa), 16);
        cyc(0, 8'h00, 1, 0, 0);
        chk("b2b_count", int'(frame_count), 3);

        // Downstream stall with 16 bytes offered
        cyc(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, 8'(i + 1), 0, 0, 0);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_frame_a", int'(fa), 1);
        chk("stall_frame_h", int'(fh), 8);
        cyc(1, 8'hFF, 0, 0, 0);
        chk("stall_hold_a", int'(fa), 1);
        cyc(0, 8'h00, 1, 0, 0);
        chk("stall_f2_a", int'(fa), 9);
        chk("stall_f2_h", int'(fh), 16);
        chk("stall_ready_back", int'(in_ready), 1);
        chk("stall_count", int'(frame_count), 1);

        // Reset while parked frame and held output exist
        cyc(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, 8'(i + 1), 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1);
        chk("rst2_valid", int'(out_valid), 0);
        chk("rst2_in_ready", int'(in_ready), 1);
        chk("rst2_frame_a", int'(fa), 0);
        chk("rst2_frame_h", int'(fh), 0);
        chk("rst2_count", int'(frame_count), 0);

        // Flush a partial frame
        cyc(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'h55 + 8'(i), 1, 0, 0);
        cyc(1, 8'hEE, 1, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'hA0 + 8'(i), 1, 0, 0);
        chk("flush_valid", int'(out_valid), 1);
        chk("flush_frame_a", int'(fa), 'hA0);
        chk("flush_frame_b", int'(fb), 'hA1);
        chk("flush_frame_h", int'(fh), 'hA7);

        // Counter wrap: preload 0xFFFF, then one more handoff
        cyc(0, 8'h00, 0, 0, 1);
        force dut.r_frame_count = 16'hFFFF;
        #1;
        release dut.r_frame_count;
        m_count = 16'hFFFF;
        cyc(0, 8'h00, 0, 0, 0);
        chk("wrap_preload", int'(frame_count), 'hFFFF);
        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        chk("wrap_count", int'(frame_count), 0);

        // Randomised traffic, first mostly flowing then mostly stalled
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, 8'($urandom),
                (i < 1500) ? (($urandom % 4) != 0) : (($urandom % 4) == 0),
                ($urandom % 40) == 0, ($urandom % 700) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
